// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage RV32 core. Each cycle it decides
// whether the front end advances, stalls on a load-use hazard, is squashed by
// a taken branch/jump resolved in EX, or freezes on a data-memory wait state.
// It also keeps saturating counters of bubble and freeze cycles.
//
// Parameters:
//   LU_BUBBLES  bubbles inserted per load-use hazard (legal range 1..3)
//   CNT_W       width of the performance counters
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1, id_rs2           source registers of the instruction in ID
//   id_use_rs1, id_use_rs2   the ID instruction really reads rs1 / rs2
//   ex_rd, ex_memread        destination / is-load of the instruction in EX
//   ex_taken                 taken branch/jump in EX this cycle
//   dm_req, dm_ready         data-memory access outstanding / completing
//   cnt_clr                  synchronous clear of both counters
//   pc_we, ifid_we           PC and IF/ID load enables
//   ifid_flush, idex_flush   IF/ID loads a NOP / ID/EX control fields zeroed
//   pipe_hold                ID/EX, EX/MEM, MEM/WB hold their contents
//   bubble_cnt, freeze_cnt   saturating performance counters
//
// There is no valid/ready handshake here: every control output is a
// combinational function of registered state and current inputs, and the
// consuming registers sample it on the same rising edge.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        LU_HOLD = 1'b1
    } state_t;

    // Remaining bubbles after the first one, loaded on LU_HOLD entry.
    localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

    state_t     state, state_nxt;
    logic [1:0] lu_left, lu_left_nxt;
    logic       lu_hit;
    logic       mem_wait;
    logic       in_hold;

    assign lu_hit = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_wait = dm_req && !dm_ready;
    assign in_hold  = (state == LU_HOLD);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            lu_left <= 2'd0;
        end else begin
            state   <= state_nxt;
            lu_left <= lu_left_nxt;
        end
    end

    // Next-state logic; a memory wait freezes everything in place.
    always_comb begin
        state_nxt   = state;
        lu_left_nxt = lu_left;
        if (!mem_wait) begin
            case (state)
                RUN: begin
                    // The first bubble is issued from RUN; LU_HOLD only
                    // covers the extra ones, so one bubble never leaves RUN.
                    if (lu_hit && !ex_taken && (LU_BUBBLES > 1)) begin
                        state_nxt   = LU_HOLD;
                        lu_left_nxt = LU_INIT;
                    end
                end
                LU_HOLD: begin
                    lu_left_nxt = lu_left - 2'd1;
                    if (lu_left == 2'd1) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Output logic in priority order. ex_taken is not looked at in LU_HOLD:
    // EX holds a bubble there and cannot legitimately raise it.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_wait) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            pipe_hold = 1'b1;
        end else if (!in_hold && ex_taken) begin
            // Squash wrong path; a load-use hit here is itself wrong-path.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (in_hold || lu_hit) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Saturating performance counters; clear beats increment.
    logic bubble_evt;
    logic freeze_evt;

    assign bubble_evt = idex_flush && !pipe_hold;
    assign freeze_evt = pipe_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            freeze_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            freeze_cnt <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
            if (freeze_evt && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It sits between the ID/EX stage register and the datapath. It decides each cycle whether the front end advances, stalls, or is squashed. It drives the `flush` input of the ID/EX register and the write-enables of PC and IF/ID. It handles three hazards: load-use hazards (with a configurable multi-cycle bubble), taken branches/jumps resolved in EX, and data-memory wait states. It also keeps saturating performance counters of bubbles and freeze cycles.

## Interface
- `LU_BUBBLES`, default 1: bubbles inserted per load-use hazard. Legal range 1–3.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source register addresses of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads `rs1` / `rs2`.
- `ex_rd`  in  5  destination address of the instruction in EX.
- `ex_memread`  in  1  the EX instruction is a load.
- `ex_taken`  in  1  a branch/jump in EX is taken; the PC mux selects the target this cycle.
- `dm_req`  in  1  the MEM stage has a data-memory access outstanding.
- `dm_ready`  in  1  data memory completes the access this cycle.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `pc_we`  out  1  PC register load enable.
- `ifid_we`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  IF/ID register loads a NOP.
- `idex_flush`  out  1  ID/EX register zeroes its control fields (bubble).
- `pipe_hold`  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- `bubble_cnt`  out  `CNT_W`  count of cycles with `idex_flush`=1 and `pipe_hold`=0.
- `freeze_cnt`  out  `CNT_W`  count of cycles with `pipe_hold`=1.

## Operation
State machine: RUN, LU_HOLD. Down-counter `lu_left` is 2 bits wide.

Hazard condition:
- `lu_hit` = `ex_memread` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- `mem_wait` = `dm_req` & !`dm_ready`.

Output priority, evaluated combinationally each cycle, highest first:
1. `rst`=1: `pc_we`=0, `ifid_we`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_hold`=0.
2. `mem_wait`: `pc_we`=0, `ifid_we`=0, `pipe_hold`=1, both flushes 0. Nothing is flushed. State, `lu_left` and all pending events are frozen.
3. `ex_taken` (RUN only): `pc_we`=1, `ifid_we`=1, `ifid_flush`=1, `idex_flush`=1. The wrong-path instructions in IF and ID are squashed. It overrides `lu_hit`, because the hazarding instruction is itself wrong-path.
4. LU_HOLD, or RUN with `lu_hit`: `pc_we`=0, `ifid_we`=0, `idex_flush`=1, `ifid_flush`=0.
5. Otherwise: `pc_we`=1, `ifid_we`=1, all flushes and `pipe_hold` 0.

`ex_taken` in LU_HOLD is ignored. EX holds a bubble there, so the EX stage must not raise it; the bench flags it as an assertion.

Transitions (none taken while `mem_wait`):
- RUN → LU_HOLD on `lu_hit` & !`ex_taken` & `LU_BUBBLES`>1. On entry, `lu_left` ← `LU_BUBBLES`−1.
- LU_HOLD: `lu_left` ← `lu_left`−1. Return to RUN in the cycle `lu_left`==1.
- RUN stays in RUN otherwise. With `LU_BUBBLES`=1 the machine never leaves RUN.

Counters:
- Saturate at all-ones and never wrap.
- `cnt_clr` has priority over increment; clear wins in the same cycle.

## Timing
- Control outputs are combinational from registered state and current inputs, with zero latency. The consuming registers sample them at the same rising edge.
- Load-use: exactly `LU_BUBBLES` consecutive cycles of `idex_flush`, not counting `mem_wait` cycles. The ID instruction re-enters ID/EX on the following edge.
- Taken branch: a single-cycle flush pulse. The target is fetched the next cycle.
- Counters update on the edge following the qualifying cycle.
- Reset values: state=RUN, `lu_left`=0, `bubble_cnt`=0, `freeze_cnt`=0.
- `rst` asserted mid-LU_HOLD returns to RUN immediately (asynchronously). The first cycle after deassertion is evaluated as RUN.
- `mem_wait` deasserting (`dm_ready`=1) resumes normal priority evaluation in that same cycle.

## Test plan
- Load-use, `LU_BUBBLES`=1: `lu x5` in EX (`ex_memread`=1, `ex_rd`=5); ID has `add` reading `rs1`=5. Required: 1 cycle `pc_we`=0, `ifid_we`=0, `idex_flush`=1, then normal; `bubble_cnt`=1.
- `LU_BUBBLES`=3, same hazard, with `mem_wait` injected for 2 cycles on the second bubble. Required: 3 flush cycles plus 2 hold cycles in between; `bubble_cnt`=3, `freeze_cnt`=2; RUN afterwards.
- `ex_taken`=1 together with `lu_hit`=1. Required: `pc_we`=1, `ifid_flush`=1, `idex_flush`=1 for one cycle; no LU_HOLD entry; the next cycle is normal.
- No-hazard filters: `ex_rd`=0 matching `rs1`=0, or a match with `id_use_rs2`=0 on `rs2`. Required: no stall, no flush.
- Counter saturation with `CNT_W`=4: force 20 bubbles. Required: `bubble_cnt`=15 held. Then `cnt_clr` together with a bubble: 0.
- Reset asserted during LU_HOLD (`LU_BUBBLES`=3, second bubble). Required: all outputs at reset values immediately; counters 0; RUN after deassertion, no residual bubble.
